// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined carry adder.
// Opcodes plus the WIDTH/STAGES legality helper used at elaboration.
package pipe_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // WIDTH must split into STAGES equal, non-empty segments.
  function automatic bit cfg_ok(int w, int s);
    return (s >= 1) && (s <= w) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple-carry segment.
// Ports: a, b, cin in; s, cout, c_msb_in (carry into top bit) out.
module rca_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb_in
);

  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit add/sub split into STAGES ripple segments, one per clock.
// Ports: clk, rst, in_valid/in_ready, A, B, Cin, op; S, Cout, ovf,
// out_valid/out_ready. Full backpressure, one op per cycle.
module pipelined_carry_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             op,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("WIDTH must be a multiple of STAGES");
  end

  // s: sum bits produced so far; c: running carry;
  // cm: carry into the MSB, only meaningful after the last segment.
  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             cm;
  } stg_t;

  stg_t q [STAGES];
  stg_t d [STAGES];

  logic [STAGES-1:0] load;
  logic              sub;

  assign sub = (op == OP_SUB);

  // A stage may load when it is empty or its content moves on.
  always_comb begin
    logic r;
    load = '0;
    r = !q[LAST].v || out_ready;
    load[LAST] = r;
    for (int k = LAST - 1; k >= 0; k--) begin
      r = !q[k].v || r;
      load[k] = r;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    stg_t           src;
    stg_t           nxt;
    logic [SEG-1:0] seg_s;
    logic           seg_co;
    logic           seg_cm;

    if (k == 0) begin : g_head
      always_comb begin
        src   = '0;
        src.v = in_valid;
        src.a = A;
        src.b = sub ? ~B : B;
        src.c = sub ? 1'b1 : Cin;
      end
    end else begin : g_body
      assign src = q[k-1];
    end

    rca_segment #(.SEG(SEG)) u_seg (
      .a        (src.a[k*SEG +: SEG]),
      .b        (src.b[k*SEG +: SEG]),
      .cin      (src.c),
      .s        (seg_s),
      .cout     (seg_co),
      .c_msb_in (seg_cm)
    );

    always_comb begin
      nxt = src;
      nxt.s[k*SEG +: SEG] = seg_s;
      nxt.c  = seg_co;
      nxt.cm = seg_cm;
    end

    assign d[k] = nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) q[k] <= d[k];
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = q[LAST].v;
  assign S         = q[LAST].s;
  assign Cout      = q[LAST].c;
  assign ovf       = q[LAST].c ^ q[LAST].cm;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder (WIDTH=32, STAGES=4).
// Directed table, streams, wrap, backpressure and mid-flight reset.
module tb_pipelined_carry_adder;

  localparam int W  = 32;
  localparam int ST = 4;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         op;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] S;
  logic         Cout;
  logic         ovf;
  logic         out_valid;
  logic         out_ready = 1'b1;

  int   checks = 0;
  int   errors = 0;
  int   n_emit = 0;
  res_t drv_exp;
  res_t exp_q [$];

  pipelined_carry_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .op        (op),
    .S         (S),
    .Cout      (Cout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, b,
                                 input logic ci, o);
    res_t         r;
    logic [W-1:0] bb;
    logic [W:0]   t;
    bb  = o ? ~b : b;
    t   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (o ? 1'b1 : ci)};
    r.s = t[W-1:0];
    r.c = t[W];
    r.o = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on emit.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_emit++;
        if (exp_q.size() == 0) begin
          chk("unexpected_emit", {32'd0, S}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("S", {32'd0, S}, {32'd0, e.s});
          chk("Cout", {63'd0, Cout}, {63'd0, e.c});
          chk("ovf", {63'd0, ovf}, {63'd0, e.o});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(drv_exp);
    end
  end

  task automatic issue(input logic [W-1:0] a, b, input logic ci, o,
                       input res_t e);
    int n;
    n = 0;
    A = a; B = b; Cin = ci; op = o; drv_exp = e;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, {32'd0, exp_q.size()}, 64'd0);
  endtask

  vec_t tbl [7];
  res_t hold;
  int   e0;

  initial begin
    tbl[0] = '{32'd0, 32'd10, 1'b0, 1'b0, 32'd10, 1'b0, 1'b0};
    tbl[1] = '{32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[2] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[3] = '{32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'd1, 1'b1, 1'b0};
    tbl[4] = '{32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[6] = '{32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_S", {32'd0, S}, 64'd0);
    chk("rst_Cout_ovf", {62'd0, Cout, ovf}, 64'd0);

    // Basic add with exact latency.
    issue(32'd0, 32'd10, 1'b0, 1'b0, model(32'd0, 32'd10, 1'b0, 1'b0));
    idle();
    chk("lat_edge0", {63'd0, out_valid}, 64'd0);
    for (int k = 1; k < ST; k++) begin
      @(posedge clk); #1;
      chk("latency", {63'd0, out_valid}, {63'd0, (k == ST - 1)});
    end
    drain("drain_basic");

    // Directed table with hand-computed results.
    for (int i = 0; i < 7; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].op,
            '{tbl[i].es, tbl[i].ec, tbl[i].eo});
    end
    idle();
    drain("drain_table");

    // 20-op back-to-back stream.
    e0 = n_emit;
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] a, b;
      a = (i < 10) ? W'(i) : 32'd3;
      b = (i < 10) ? 32'd100 : W'(i);
      issue(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0));
    end
    idle();
    drain("drain_stream");
    chk("stream_count", {32'd0, n_emit - e0}, 64'd20);

    // Wrap-around across 2^32.
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] b;
      b = W'(i);
      issue(32'hFFFF_FFFC, b, 1'b0, 1'b0,
            model(32'hFFFF_FFFC, b, 1'b0, 1'b0));
    end
    idle();
    drain("drain_wrap");

    // Backpressure: 8 stalled cycles mid-stream.
    e0 = n_emit;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [W-1:0] a;
          a = W'(i * 1000 + 1);
          issue(a, 32'd77, 1'b1, 1'b0, model(a, 32'd77, 1'b1, 1'b0));
        end
        idle();
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        hold.s = S; hold.c = Cout; hold.o = ovf;
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        for (int k = 1; k < 8; k++) begin
          @(negedge clk);
          chk("stall_S", {32'd0, S}, {32'd0, hold.s});
          chk("stall_C", {62'd0, Cout, ovf}, {62'd0, hold.c, hold.o});
        end
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    chk("bp_count", {32'd0, n_emit - e0}, 64'd12);

    // Random backpressure to squeeze bubbles.
    e0 = n_emit;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [W-1:0] a, b;
          logic         o;
          a = $urandom; b = $urandom; o = 1'($urandom_range(0, 1));
          issue(a, b, 1'b0, o, model(a, b, 1'b0, o));
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk); #1;
          end
        end
        idle();
      end
      begin
        repeat (60) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_rand");
    chk("rand_count", {32'd0, n_emit - e0}, 64'd16);

    // Reset with three operations in flight.
    e0 = n_emit;
    for (int i = 0; i < 3; i++) begin
      issue(W'(i + 50), 32'd1, 1'b0, 1'b0,
            model(W'(i + 50), 32'd1, 1'b0, 1'b0));
    end
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_emit", {32'd0, n_emit - e0}, 64'd0);
    issue(32'd123, 32'd456, 1'b0, 1'b0,
          model(32'd123, 32'd456, 1'b0, 1'b0));
    idle();
    drain("drain_after_rst");
    chk("after_rst_count", {32'd0, n_emit - e0}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
